// File: rtl/key_scan.sv
// Piano input front end: synchronizes and debounces eight note switches and two
// octave buttons, tracks the octave range and encodes the lowest held note.
// Define KEY_SCAN_WRAP_EN to make the octave range wrap instead of saturating.
module key_scan #(
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] sw_raw,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] sw_stable,
  output logic [1:0] state,
  output logic       note_valid,
  output logic [2:0] note_idx,
  output logic       oct_chg
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    LO = 2'b00,
    MI = 2'b01,
    HI = 2'b10
  } oct_t;

  oct_t          oct;
  logic [9:0]    raw;
  logic [9:0]    meta;
  logic [9:0]    sync;
  logic [9:0]    deb;
  logic [CW-1:0] cnt [10];
  logic [1:0]    sync_vld;
  logic [1:0]    btn_prev;
  logic [1:0]    btn_arm;
  logic          up_edge;
  logic          dn_edge;
  logic [2:0]    idx_nxt;

  // Bits 7:0 are the note switches, bit 8 is octave-up, bit 9 is octave-down.
  assign raw = {btn_down, btn_up, sw_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= '0;
      sync     <= '0;
      sync_vld <= '0;
    end else begin
      meta     <= raw;
      sync     <= meta;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 10; i++) cnt[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 10; i++) begin
        if (sync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A button only counts once it has been seen released since reset, so a
  // button held through reset cannot fire a spurious octave change.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_arm <= '0;
    end else if (sync_vld[1]) begin
      btn_arm <= btn_arm | ~sync[9:8];
    end
  end

  assign up_edge = deb[8] & ~btn_prev[0] & btn_arm[0];
  assign dn_edge = deb[9] & ~btn_prev[1] & btn_arm[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      oct      <= MI;
      oct_chg  <= 1'b0;
      btn_prev <= '0;
    end else if (en) begin
      btn_prev <= deb[9:8];
      oct_chg  <= 1'b0;
      if (up_edge && !dn_edge) begin
        case (oct)
          LO: begin
            oct     <= MI;
            oct_chg <= 1'b1;
          end
          MI: begin
            oct     <= HI;
            oct_chg <= 1'b1;
          end
          HI: begin
`ifdef KEY_SCAN_WRAP_EN
            oct     <= LO;
            oct_chg <= 1'b1;
`else
            oct     <= HI;
`endif
          end
          default: oct <= MI;
        endcase
      end else if (dn_edge && !up_edge) begin
        case (oct)
          HI: begin
            oct     <= MI;
            oct_chg <= 1'b1;
          end
          MI: begin
            oct     <= LO;
            oct_chg <= 1'b1;
          end
          LO: begin
`ifdef KEY_SCAN_WRAP_EN
            oct     <= HI;
            oct_chg <= 1'b1;
`else
            oct     <= LO;
`endif
          end
          default: oct <= MI;
        endcase
      end
    end
  end

  always_comb begin
    idx_nxt = '0;
    for (int i = 7; i >= 0; i--) begin
      if (deb[i]) idx_nxt = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_valid <= 1'b0;
      note_idx   <= '0;
    end else if (en) begin
      note_valid <= |deb[7:0];
      note_idx   <= idx_nxt;
    end
  end

  assign sw_stable = deb[7:0];
  assign state     = oct;

endmodule
